// File: rtl/arith_unit_seq.sv
// Sequential integer arithmetic unit: single-cycle add/sub, two-stage multiply and
// an iterative radix-2 restoring divider, with valid/ready handshakes on both sides.
module arith_unit_seq #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned DIV_EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] arg0,
  input  logic [XLEN-1:0] arg1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            carry,
  output logic            div_zero,
  output logic            illegal
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB  = 4'd1, OP_MUL  = 4'd2, OP_DIV  = 4'd3,
    OP_MOD  = 4'd4, OP_SADD = 4'd5, OP_SSUB = 4'd6, OP_SMUL = 4'd7,
    OP_SDIV = 4'd8, OP_SMOD = 4'd9, OP_INC  = 4'd10, OP_DEC = 4'd11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_EXEC, S_MUL1, S_MUL2, S_DIVZ, S_DIV_PREP, S_DIV_LOOP, S_DIV_FIX, S_DONE
  } state_e;

  localparam logic [7:0] XLEN8 = 8'(XLEN);

  state_e            state;
  logic [3:0]        op_q;
  logic [7:0]        w_q;
  logic [XLEN-1:0]   m_q, a_q, b_q;
  logic              ill_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q;
  logic [7:0]        cnt_q;
  logic              qneg_q, rneg_q;

  logic              accept;
  logic [7:0]        w_in;
  logic [XLEN-1:0]   m_in;
  logic              ill_in;
  state_e            path;

  assign in_ready = rst_n && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    w_in   = 8'd8 << size;
    m_in   = (XLEN'(1) << w_in) - XLEN'(1);
    ill_in = (op > 4'd11) || (w_in > XLEN8);
    path   = S_EXEC;
    if (!ill_in) begin
      case (op)
        OP_MUL, OP_SMUL:                 path = S_MUL1;
        OP_DIV, OP_MOD, OP_SDIV, OP_SMOD: path = ((arg1 & m_in) == '0) ? S_DIVZ : S_DIV_PREP;
        default:                         path = S_EXEC;
      endcase
    end
  end

  logic [XLEN-1:0]   min_w, addend, exec_res, abs_a, abs_b, div_sub, q_fix, r_fix, mul_lo;
  logic [XLEN:0]     sum, trial;
  logic              sign_a, sign_b, is_add, is_sdiv, is_quo, exec_c, div_ge, div_ovf, mul_c;
  logic [2*XLEN-1:0] mx, my, mul_ext;

  always_comb begin
    min_w    = m_q ^ (m_q >> 1);
    sign_a   = |(a_q & min_w);
    sign_b   = |(b_q & min_w);
    is_add   = (op_q == OP_ADD) || (op_q == OP_SADD) || (op_q == OP_INC);
    is_sdiv  = (op_q == OP_SDIV) || (op_q == OP_SMOD);
    is_quo   = (op_q == OP_DIV) || (op_q == OP_SDIV);
    addend   = ((op_q == OP_INC) || (op_q == OP_DEC)) ? XLEN'(1) : b_q;
    sum      = {1'b0, a_q} + {1'b0, addend};
    exec_res = '0;
    exec_c   = 1'b0;
    if (!ill_q) begin
      exec_res = is_add ? (sum[XLEN-1:0] & m_q) : ((a_q - addend) & m_q);
      exec_c   = is_add ? |(sum & ((XLEN+1)'(1) << w_q)) : (a_q < addend);
    end

    // Signed operands are sign-extended to 2*XLEN so one unsigned multiplier serves both.
    mx = ((op_q == OP_SMUL) && sign_a) ? {{XLEN{1'b1}}, a_q | ~m_q} : {{XLEN{1'b0}}, a_q};
    my = ((op_q == OP_SMUL) && sign_b) ? {{XLEN{1'b1}}, b_q | ~m_q} : {{XLEN{1'b0}}, b_q};
    mul_lo  = prod_q[XLEN-1:0] & m_q;
    mul_ext = |(mul_lo & min_w) ? {{XLEN{1'b1}}, mul_lo | ~m_q} : {{XLEN{1'b0}}, mul_lo};
    mul_c   = (op_q == OP_SMUL) ? (mul_ext != prod_q) : ((prod_q >> w_q) != '0);

    abs_a   = (is_sdiv && sign_a) ? ((~a_q + XLEN'(1)) & m_q) : a_q;
    abs_b   = (is_sdiv && sign_b) ? ((~b_q + XLEN'(1)) & m_q) : b_q;
    trial   = {rem_q, quo_q[XLEN-1]};
    div_ge  = trial >= {1'b0, dvs_q};
    div_sub = trial[XLEN-1:0] - dvs_q;
    q_fix   = qneg_q ? ((~quo_q + XLEN'(1)) & m_q) : quo_q;
    r_fix   = rneg_q ? ((~rem_q + XLEN'(1)) & m_q) : rem_q;
    div_ovf = is_sdiv && (a_q == min_w) && (b_q == m_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_EXEC: begin
          result    <= exec_res;
          carry     <= exec_c;
          div_zero  <= 1'b0;
          illegal   <= ill_q;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_MUL1: begin
          prod_q <= mx * my;
          state  <= S_MUL2;
        end
        S_MUL2: begin
          result    <= mul_lo;
          carry     <= mul_c;
          div_zero  <= 1'b0;
          illegal   <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DIVZ: begin
          result    <= is_quo ? m_q : a_q;
          carry     <= 1'b0;
          div_zero  <= 1'b1;
          illegal   <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DIV_PREP: begin
          // Early-out left-aligns the dividend so only W quotient bits are iterated.
          quo_q  <= (DIV_EARLY_OUT != 0) ? (abs_a << (XLEN8 - w_q)) : abs_a;
          dvs_q  <= abs_b;
          rem_q  <= '0;
          cnt_q  <= ((DIV_EARLY_OUT != 0) ? w_q : XLEN8) - 8'd1;
          qneg_q <= is_sdiv && (sign_a ^ sign_b);
          rneg_q <= is_sdiv && sign_a;
          state  <= S_DIV_LOOP;
        end
        S_DIV_LOOP: begin
          rem_q <= div_ge ? div_sub : trial[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], div_ge};
          if (cnt_q == 8'd0) state <= S_DIV_FIX;
          else               cnt_q <= cnt_q - 8'd1;
        end
        S_DIV_FIX: begin
          result    <= is_quo ? q_fix : r_fix;
          carry     <= div_ovf;
          div_zero  <= 1'b0;
          illegal   <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: ;
      endcase
      if (accept) begin
        op_q  <= op;
        w_q   <= w_in;
        m_q   <= m_in;
        a_q   <= arg0 & m_in;
        b_q   <= arg1 & m_in;
        ill_q <= ill_in;
        state <= path;
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Randomized scoreboard bench for arith_unit_seq: a plain-arithmetic model predicts each
// accepted request's outputs and latency; one negedge process checks the DUT every cycle.
module tb_arith_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, carry, div_zero, illegal;
  logic [3:0]  op;
  logic [1:0]  size;
  logic [63:0] arg0, arg1, result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [63:0] r;
    logic        c, dz, il;
    int          acc, lat;
  } exp_t;
  exp_t q[$];

  arith_unit_seq #(.XLEN(64), .DIV_EARLY_OUT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .size(size), .arg0(arg0), .arg1(arg1),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [3:0] o, input logic [1:0] sz, input logic [63:0] x, y,
                                output logic [63:0] r, output logic c, dz, il, output int lat);
    int w;
    logic [63:0] m, a, b, bb;
    longint sa, sb, minv, qq;
    logic [64:0] s;
    logic [127:0] p;
    logic signed [127:0] xa, xb, sp, lim;
    w = 8 << sz;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    a = x & m;
    b = y & m;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    r = '0; c = 1'b0; dz = 1'b0; il = 1'b0; lat = 2;
    case (o)
      4'd0, 4'd5, 4'd10: begin
        bb = (o == 4'd10) ? 64'd1 : b;
        s  = {1'b0, a} + {1'b0, bb};
        r  = s[63:0] & m;
        c  = s[w];
      end
      4'd1, 4'd6, 4'd11: begin
        bb = (o == 4'd11) ? 64'd1 : b;
        r  = (a - bb) & m;
        c  = a < bb;
      end
      4'd2: begin
        p = {64'd0, a} * {64'd0, b};
        r = p[63:0] & m;
        c = (p >> w) != '0;
        lat = 3;
      end
      4'd7: begin
        xa = sa; xb = sb;
        sp = xa * xb;
        r  = sp[63:0] & m;
        lim = 128'sd1 <<< (w - 1);
        c  = (sp >= lim) || (sp < -lim);
        lat = 3;
      end
      4'd3, 4'd4, 4'd8, 4'd9: begin
        if (b == '0) begin
          dz = 1'b1;
          r  = (o == 4'd3 || o == 4'd8) ? m : a;
        end else begin
          lat  = w + 3;
          minv = -(64'sd1 <<< (w - 1));
          if (o == 4'd3)      r = a / b;
          else if (o == 4'd4) r = a % b;
          else if (sa == minv && sb == -64'sd1) begin
            c = 1'b1;
            r = (o == 4'd8) ? a : 64'd0;
          end else begin
            qq = (o == 4'd8) ? sa / sb : sa % sb;
            r  = 64'(qq) & m;
          end
        end
      end
      default: il = 1'b1;
    endcase
  endfunction

  // Per-cycle scoreboard: output valid/ready timing and values versus model.
  int rst_cnt = 0;
  always @(negedge clk) begin
    logic ev, rdy_exp;
    exp_t e;
    if (!rst_n) begin
      rst_cnt++;
      chk1("in_ready_rst", in_ready, 1'b0);
      if (rst_cnt >= 2) begin
        chk1("out_valid_rst", out_valid, 1'b0);
        chk64("result_rst", result, 64'd0);
        chk1("flags_rst", carry | div_zero | illegal, 1'b0);
      end
      q.delete();
    end else begin
      rst_cnt = 0;
      ev = (q.size() > 0) && ((cyc - q[0].acc) >= q[0].lat);
      rdy_exp = (q.size() == 0) || (ev && out_ready);
      chk1("out_valid", out_valid, ev);
      chk1("in_ready", in_ready, rdy_exp);
      if (ev) begin
        chk64("result", result, q[0].r);
        chk1("carry", carry, q[0].c);
        chk1("div_zero", div_zero, q[0].dz);
        chk1("illegal", illegal, q[0].il);
        if (out_ready) void'(q.pop_front());
      end else begin
        chk64("result_idle", result, 64'd0);
        chk1("flags_idle", carry | div_zero | illegal, 1'b0);
      end
      if (in_valid && rdy_exp) begin
        model(op, size, arg0, arg1, e.r, e.c, e.dz, e.il, e.lat);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [3:0] o, input logic [1:0] s, input logic [63:0] x, y);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; op = o; size = s; arg0 = x; arg1 = y;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op   = 4'($urandom);
    arg0 = {$urandom, $urandom};
    arg1 = {$urandom, $urandom};
    chk1("accept_timeout", got, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk64("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick(input logic [1:0] sz);
    logic [63:0] v;
    v = 64'd1;
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'd1;
      3:       return v << ((8 << sz) - 1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] r;
    logic c, dz, il;
    int lat;
    logic [3:0] o;
    logic [1:0] s;

    // Hand-computed expectations pinning the model.
    model(4'd0, 2'd0, 64'hFF, 64'h01, r, c, dz, il, lat);
    chk64("pin_add_r", r, 64'h00); chk1("pin_add_c", c, 1'b1);
    model(4'd1, 2'd1, 64'h0, 64'h1, r, c, dz, il, lat);
    chk64("pin_sub_r", r, 64'hFFFF); chk1("pin_sub_c", c, 1'b1);
    model(4'd7, 2'd2, 64'h7FFFFFFF, 64'd2, r, c, dz, il, lat);
    chk64("pin_smul_r", r, 64'hFFFFFFFE); chk1("pin_smul_c", c, 1'b1);
    model(4'd2, 2'd3, 64'd3, 64'd5, r, c, dz, il, lat);
    chk64("pin_mul_r", r, 64'd15); chk64("pin_mul_lat", 64'(lat), 64'd3);
    model(4'd8, 2'd0, 64'hF9, 64'h02, r, c, dz, il, lat);
    chk64("pin_sdiv_r", r, 64'hFD); chk64("pin_sdiv_lat", 64'(lat), 64'd11);
    model(4'd9, 2'd0, 64'hF9, 64'h02, r, c, dz, il, lat);
    chk64("pin_smod_r", r, 64'hFF);
    model(4'd8, 2'd0, 64'h80, 64'hFF, r, c, dz, il, lat);
    chk64("pin_ovf_r", r, 64'h80); chk1("pin_ovf_c", c, 1'b1);
    model(4'd3, 2'd3, 64'h1234, 64'h0, r, c, dz, il, lat);
    chk64("pin_dz_r", r, '1); chk1("pin_dz_f", dz, 1'b1);
    model(4'd4, 2'd3, 64'h1234, 64'h0, r, c, dz, il, lat);
    chk64("pin_mz_r", r, 64'h1234);

    // Reset held with a pending request.
    rst_n = 1'b0; in_valid = 1'b1; op = '0; size = '0; arg0 = '0; arg1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;

    // Directed sequence, issued back to back.
    send(4'd0, 2'd0, 64'hFF, 64'h01);
    send(4'd1, 2'd1, 64'h0, 64'h1);
    send(4'd7, 2'd2, 64'h7FFFFFFF, 64'd2);
    send(4'd2, 2'd3, 64'd3, 64'd5);
    send(4'd8, 2'd0, 64'hABCD_0000_0000_00F9, 64'h1111_0000_0000_0002);
    send(4'd9, 2'd0, 64'hF9, 64'h02);
    send(4'd8, 2'd0, 64'h80, 64'hFF);
    send(4'd3, 2'd3, 64'h1234, 64'h0);
    send(4'd4, 2'd3, 64'h1234, 64'h0);
    send(4'd13, 2'd1, 64'h5, 64'h6);
    drain();

    // Backpressure: result must stay put with in_ready low.
    rdy_mode = 1;
    send(4'd0, 2'd2, 64'h8000_0001, 64'h8000_0002);
    repeat (8) begin @(posedge clk); #1; end
    rdy_mode = 0;
    drain();

    // Reset in the middle of a long divide: no result may appear.
    send(4'd3, 2'd3, {$urandom, $urandom}, 64'd7);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (80) begin @(posedge clk); #1; end

    // Randomized traffic with random consumer stalls.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      s = 2'($urandom_range(0, 3));
      send(o, s, pick(s), pick(s));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
